// File: rtl/data_types_pkg.sv
// Shared data types for the data-memory models: 32-bit words, request/response
// records and a byte-enable merge helper.
package data_types_pkg;

    localparam int DMEM_TAG_W = 4;

    typedef logic [31:0] word32_t;

    typedef struct packed {
        logic                  write;
        logic [3:0]            be;
        word32_t               addr;
        word32_t               data;
        logic [DMEM_TAG_W-1:0] tag;
    } dmem_req_t;

    typedef struct packed {
        logic                  write;
        logic                  err;
        logic [DMEM_TAG_W-1:0] tag;
        word32_t               data;
    } dmem_rsp_t;

    function automatic word32_t be_merge(input word32_t old_w, input word32_t new_w,
                                         input logic [3:0] be);
        word32_t res;
        res = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) res[8*b +: 8] = new_w[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered storage; pointers carry one extra wrap bit so
// full and empty are told apart by the pointer difference.
module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_POW2 = 2
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int DEPTH = 1 << DEPTH_POW2;
    typedef logic [DEPTH_POW2:0] ptr_t;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    ptr_t             wr_ptr_q, wr_ptr_d;
    ptr_t             rd_ptr_q, rd_ptr_d;
    ptr_t             fill;

    assign fill      = wr_ptr_q - rd_ptr_q;
    assign empty_o   = (fill == '0);
    assign full_o    = (fill == ptr_t'(DEPTH));
    assign rd_data_o = mem_q[rd_ptr_q[DEPTH_POW2-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en_i) begin
            mem_d[wr_ptr_q[DEPTH_POW2-1:0]] = wr_data_i;
            wr_ptr_d = wr_ptr_q + ptr_t'(1);
        end
        if (rd_en_i) rd_ptr_d = rd_ptr_q + ptr_t'(1);
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/pipelined_dmem_model.sv
// Word-addressed data memory with byte enables, tagged in-order responses and a
// credit-limited response FIFO. Define DMEM_OOR_ERR_EN to flag out-of-range addresses.
module pipelined_dmem_model
    import data_types_pkg::*;
#(
    parameter int SIZE_POW2      = 5,
    parameter int LATENCY        = 2,
    parameter int TAG_W          = DMEM_TAG_W,
    parameter int RSP_DEPTH_POW2 = 2
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_write_i,
    input  logic [3:0]       req_be_i,
    input  word32_t          req_addr_i,
    input  word32_t          req_data_i,
    input  logic [TAG_W-1:0] req_tag_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic             rsp_write_o,
    output logic             rsp_err_o,
    output logic [TAG_W-1:0] rsp_tag_o,
    output word32_t          rsp_data_o
);

    localparam int WORDS     = 1 << SIZE_POW2;
    localparam int RSP_DEPTH = 1 << RSP_DEPTH_POW2;
    typedef logic [RSP_DEPTH_POW2:0] cnt_t;

    // Same fields as dmem_rsp_t, with the tag sized by TAG_W.
    typedef struct packed {
        logic             write;
        logic             err;
        logic [TAG_W-1:0] tag;
        word32_t          data;
    } rsp_t;

    typedef struct packed {
        logic valid;
        rsp_t rsp;
    } stage_t;

    word32_t              mem_q  [WORDS];
    word32_t              mem_d  [WORDS];
    stage_t               pipe_q [LATENCY];
    stage_t               pipe_d [LATENCY];
    cnt_t                 cnt_q, cnt_d;
    logic                 live_q;
    rsp_t                 last_q, last_d;

    logic [SIZE_POW2-1:0] word_idx;
    logic                 oor;
    logic                 accept;
    logic                 pop;
    rsp_t                 head;
    rsp_t                 rsp_out;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 unused_addr;

    assign word_idx    = req_addr_i[SIZE_POW2+1:2];
    assign unused_addr = ^{req_addr_i[31:SIZE_POW2+2], req_addr_i[1:0]};

`ifdef DMEM_OOR_ERR_EN
    assign oor = |req_addr_i[31:SIZE_POW2+2];
`else
    assign oor = 1'b0;
`endif

    // The credit covers pipeline plus FIFO, so a granted request always finds a FIFO slot.
    assign req_ready_o = live_q && (cnt_q < cnt_t'(RSP_DEPTH));
    assign accept      = req_valid_i && req_ready_o;
    assign pop         = rsp_ready_i && !fifo_empty;

    always_comb begin
        // NOTE: every *_d gets a full default first so no path can infer a latch.
        mem_d  = mem_q;
        pipe_d = pipe_q;
        cnt_d  = cnt_q;
        last_d = last_q;

        if (accept && req_write_i && !oor)
            mem_d[word_idx] = be_merge(mem_q[word_idx], req_data_i, req_be_i);

        // Stage 0 is the accept-edge sample; the remaining LATENCY-1 stages only shift.
        pipe_d[0].valid     = accept;
        pipe_d[0].rsp.write = req_write_i;
        pipe_d[0].rsp.err   = oor;
        pipe_d[0].rsp.tag   = req_tag_i;
        pipe_d[0].rsp.data  = (req_write_i || oor) ? '0 : mem_q[word_idx];
        for (int i = 1; i < LATENCY; i++) pipe_d[i] = pipe_q[i-1];

        case ({accept, pop})
            2'b10:   cnt_d = cnt_q + cnt_t'(1);
            2'b01:   cnt_d = cnt_q - cnt_t'(1);
            default: cnt_d = cnt_q;
        endcase

        if (pop) last_d = head;
    end

    sync_fifo #(
        .WIDTH      ($bits(rsp_t)),
        .DEPTH_POW2 (RSP_DEPTH_POW2)
    ) u_rsp_fifo (
        .clk_i     (clk_i),
        .reset_ni  (reset_ni),
        .wr_en_i   (pipe_q[LATENCY-1].valid),
        .wr_data_i (pipe_q[LATENCY-1].rsp),
        .rd_en_i   (pop),
        .rd_data_o (head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    // With the FIFO empty, the last dequeued response stays on rsp_*.
    assign rsp_out     = fifo_empty ? last_q : head;
    assign rsp_valid_o = !fifo_empty;
    assign rsp_write_o = rsp_out.write;
    assign rsp_err_o   = rsp_out.err;
    assign rsp_tag_o   = rsp_out.tag;
    assign rsp_data_o  = rsp_out.data;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            // NOTE: the memory array is reset deliberately: loads after reset must return 0.
            mem_q  <= '{default: '0};
            pipe_q <= '{default: '0};
            cnt_q  <= '0;
            live_q <= 1'b0;
            last_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            mem_q  <= mem_d;
            pipe_q <= pipe_d;
            cnt_q  <= cnt_d;
            live_q <= 1'b1;
            last_q <= last_d;
        end
    end

    a_no_fifo_overflow: assert property (@(posedge clk_i) disable iff (!reset_ni)
        !(pipe_q[LATENCY-1].valid && fifo_full));

endmodule

// File: tb/tb_pipelined_dmem_model.sv
// Self-checking bench for pipelined_dmem_model: directed scenarios plus random traffic
// compared against a queue-based reference model of the memory and its responses.
module tb_pipelined_dmem_model;

    localparam int SIZE_POW2      = 5;
    localparam int LATENCY        = 2;
    localparam int TAG_W          = 4;
    localparam int RSP_DEPTH_POW2 = 2;
    localparam int RSP_DEPTH      = 1 << RSP_DEPTH_POW2;
    localparam int WORDS          = 1 << SIZE_POW2;

    logic             clk_i = 1'b0;
    logic             reset_ni;
    logic             req_valid_i;
    logic             req_ready_o;
    logic             req_write_i;
    logic [3:0]       req_be_i;
    logic [31:0]      req_addr_i;
    logic [31:0]      req_data_i;
    logic [TAG_W-1:0] req_tag_i;
    logic             rsp_valid_o;
    logic             rsp_ready_i;
    logic             rsp_write_o;
    logic             rsp_err_o;
    logic [TAG_W-1:0] rsp_tag_o;
    logic [31:0]      rsp_data_o;

    pipelined_dmem_model #(
        .SIZE_POW2      (SIZE_POW2),
        .LATENCY        (LATENCY),
        .TAG_W          (TAG_W),
        .RSP_DEPTH_POW2 (RSP_DEPTH_POW2)
    ) dut (
        .clk_i       (clk_i),
        .reset_ni    (reset_ni),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_write_i (req_write_i),
        .req_be_i    (req_be_i),
        .req_addr_i  (req_addr_i),
        .req_data_i  (req_data_i),
        .req_tag_i   (req_tag_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_write_o (rsp_write_o),
        .rsp_err_o   (rsp_err_o),
        .rsp_tag_o   (rsp_tag_o),
        .rsp_data_o  (rsp_data_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: outstanding responses in acceptance order, each with the edge
    // after which it may first appear.
    typedef struct {
        logic             write;
        logic             err;
        logic [TAG_W-1:0] tag;
        logic [31:0]      data;
        int               due;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ref_mem [WORDS];
    bit          live;
    int          edge_n;
    int          n_tests;
    int          n_fail;
    int          dut_acc;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (edge %0d)", name, got, exp, edge_n);
        end
    endtask

    function automatic bit model_ready();
        return live && (exp_q.size() < RSP_DEPTH);
    endfunction

    function automatic bit model_valid();
        return (exp_q.size() > 0) && (exp_q[0].due <= edge_n);
    endfunction

    task automatic model_accept();
        exp_t e;
        int   idx;
        bit   oor;
        idx = int'(req_addr_i[SIZE_POW2+1:2]);
        oor = 1'b0;
`ifdef DMEM_OOR_ERR_EN
        oor = (req_addr_i >> (SIZE_POW2 + 2)) != 0;
`endif
        e.write = req_write_i;
        e.err   = oor;
        e.tag   = req_tag_i;
        e.due   = edge_n + LATENCY;
        e.data  = '0;
        if (req_write_i) begin
            if (!oor)
                for (int b = 0; b < 4; b++)
                    if (req_be_i[b]) ref_mem[idx][8*b +: 8] = req_data_i[8*b +: 8];
        end else if (!oor) begin
            e.data = ref_mem[idx];
        end
        exp_q.push_back(e);
    endtask

    task automatic compare();
        check("req_ready", req_ready_o, model_ready());
        check("rsp_valid", rsp_valid_o, model_valid());
        if (model_valid()) begin
            check("rsp_tag",   rsp_tag_o,   exp_q[0].tag);
            check("rsp_write", rsp_write_o, exp_q[0].write);
            check("rsp_err",   rsp_err_o,   exp_q[0].err);
            check("rsp_data",  rsp_data_o,  exp_q[0].data);
        end
    endtask

    // Called just after a falling edge; inputs are held across the next rising edge.
    task automatic step();
        bit acc;
        bit pp;
        acc = reset_ni && req_valid_i && model_ready();
        pp  = model_valid() && rsp_ready_i;
        if (req_valid_i && req_ready_o) dut_acc++;
        @(posedge clk_i);
        edge_n++;
        if (pp) void'(exp_q.pop_front());
        if (acc) model_accept();
        live = reset_ni;
        @(negedge clk_i);
        compare();
    endtask

    task automatic set_req(input bit v, input bit w, input logic [3:0] be,
                           input logic [31:0] a, input logic [31:0] d, input logic [TAG_W-1:0] t);
        req_valid_i = v;
        req_write_i = w;
        req_be_i    = be;
        req_addr_i  = a;
        req_data_i  = d;
        req_tag_i   = t;
    endtask

    task automatic idle();
        set_req(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, '0);
    endtask

    task automatic drain();
        idle();
        rsp_ready_i = 1'b1;
        repeat (LATENCY + RSP_DEPTH + 2) step();
    endtask

    task automatic do_reset();
        reset_ni = 1'b0;
        idle();
        #1;
        check("rst_ready", req_ready_o, 1'b0);
        check("rst_valid", rsp_valid_o, 1'b0);
        check("rst_write", rsp_write_o, 1'b0);
        check("rst_err",   rsp_err_o,   1'b0);
        check("rst_tag",   rsp_tag_o,   '0);
        check("rst_data",  rsp_data_o,  32'h0);
        exp_q.delete();
        for (int i = 0; i < WORDS; i++) ref_mem[i] = '0;
        live = 1'b0;
        @(negedge clk_i);
        reset_ni = 1'b1;
        compare();
        step();
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return $urandom;
        return 32'($urandom_range(0, 4 * WORDS - 1));
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        edge_n      = 0;
        dut_acc     = 0;
        reset_ni    = 1'b0;
        rsp_ready_i = 1'b1;
        idle();
        @(negedge clk_i);
        do_reset();

        // Load after reset: tag 3, data 0, two cycles of latency.
        set_req(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 4'd3);
        step();
        idle();
        repeat (3) step();

        // Partial store followed by a load of the same word.
        set_req(1'b1, 1'b1, 4'b0101, 32'h4, 32'hAABBCCDD, 4'd1);
        step();
        set_req(1'b1, 1'b0, 4'h0, 32'h4, 32'h0, 4'd2);
        step();
        drain();

        // Six back-to-back loads against a stalled consumer: four credits only.
        rsp_ready_i = 1'b0;
        dut_acc     = 0;
        for (int i = 0; i < 6; i++) begin
            set_req(1'b1, 1'b0, 4'h0, 32'(4 * i), 32'h0, 4'(i + 4));
            step();
        end
        idle();
        check("accepts_of_six", dut_acc, 4);
        rsp_ready_i = 1'b1;
        repeat (6) step();

        // Continuous traffic with a free-flowing consumer.
        for (int i = 0; i < 20; i++) begin
            set_req(1'b1, i[0], 4'hF, 32'(4 * (i % 8)), $urandom, 4'(i));
            step();
        end
        drain();

        // Reset with requests in flight: nothing comes out, memory reads back 0.
        set_req(1'b1, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 4'd5);
        step();
        set_req(1'b1, 1'b1, 4'hF, 32'h14, 32'h01234567, 4'd6);
        step();
        set_req(1'b1, 1'b0, 4'h0, 32'h10, 32'h0, 4'd7);
        step();
        do_reset();
        repeat (4) step();
        set_req(1'b1, 1'b0, 4'h0, 32'h10, 32'h0, 4'd8);
        step();
        set_req(1'b1, 1'b0, 4'h0, 32'h14, 32'h0, 4'd9);
        step();
        drain();

        // Store just past the top of memory, then read word 0.
        set_req(1'b1, 1'b1, 4'hF, 32'h0, 32'hCAFEF00D, 4'd10);
        step();
        set_req(1'b1, 1'b1, 4'hF, 32'h80, 32'h11223344, 4'd11);
        step();
        set_req(1'b1, 1'b0, 4'h0, 32'h80, 32'h0, 4'd12);
        step();
        set_req(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 4'd13);
        step();
        drain();

        // Random traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            set_req($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 4'($urandom),
                    rand_addr(), $urandom, 4'($urandom));
            rsp_ready_i = $urandom_range(0, 3) != 0;
            step();
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
